// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: pc_src encodings, FSM states, vectors, queue entry.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_B   = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b100;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc_plus4;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: circular FIFO with push/pop/flush; flush may load one entry.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;

  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign count   = wptr - rptr;
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign wr_en   = flush ? push : do_push;
  assign wr_idx  = flush ? '0 : wptr[AW-1:0];
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk)
    if (wr_en)
      mem[wr_idx] <= din;

  // A flush restarts at slot 0, optionally holding the entry pushed with it
  always_ff @(posedge clk)
    if (!reset_b) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= {{AW{1'b0}}, push};
    end else begin
      if (do_push)
        wptr <= wptr + (AW+1)'(1);
      if (do_pop)
        rptr <= rptr + (AW+1)'(1);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, DEPTH-entry queue to ID.
// Optional irq context save/restore under FETCH_IRQ_CONTEXT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 2,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] IRQ_VEC   = XLEN'(DEF_IRQ_VEC),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEF_EXC_VEC)
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic [2:0]      pc_src,
  input  logic [XLEN-1:0] branch_address,
  input  logic [XLEN-1:0] jump_address,
  input  logic [XLEN-1:0] jr_address,
  input  logic            intruption,
  input  logic            exception,
  input  logic            if_flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [XLEN-1:0] id_instr,
  input  logic            irq_backup,
  input  logic            irq_recovery
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * XLEN;
  localparam logic [XLEN-2:0] STEP = (XLEN-1)'(4);

  fetch_state_e    state;
  fetch_state_e    state_nx;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nx;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] tgt_pc;
  logic [XLEN-1:0] req_tag;
  logic            trap;
  logic            redirect;
  logic            recover;
  logic            grant;
  logic            fresh;
  logic            room;
  logic            push;
  logic            pop;
  logic            q_full;
  logic            q_empty;
  logic [AW:0]     q_count;
  logic [AW+1:0]   fill_nx;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;
  logic [XLEN-1:0] rec_pc;
  logic            rec_push;
  logic [EW-1:0]   rec_data;

`ifdef FETCH_IRQ_CONTEXT_EN
  logic [XLEN-1:0] bk_pc;
  logic [EW-1:0]   bk_head;
  logic            bk_valid;

  always_ff @(posedge clk)
    if (!reset_b) begin
      bk_pc    <= RESET_VEC;
      bk_head  <= '0;
      bk_valid <= 1'b0;
    end else if (irq_backup & ~irq_recovery) begin
      bk_pc    <= pc;
      bk_head  <= {id_pc_plus4, id_instr};
      bk_valid <= id_valid;
    end

  assign recover  = irq_recovery;
  assign rec_pc   = bk_pc;
  assign rec_push = bk_valid;
  assign rec_data = bk_head;
`else
  logic unused_ctx;
  assign unused_ctx = irq_backup ^ irq_recovery;
  assign recover    = 1'b0;
  assign rec_pc     = pc;
  assign rec_push   = 1'b0;
  assign rec_data   = '0;
`endif

  // Kernel mode (pc MSB set) masks traps
  assign trap     = ~pc[XLEN-1] & (intruption | exception);
  assign redirect = recover | trap | (pc_src != PCSRC_SEQ) | if_flush;
  assign seq_pc   = {pc[XLEN-1], pc[XLEN-2:0] + STEP};
  assign grant    = imem_req & imem_gnt;
  assign fresh    = (state == WAIT) & imem_rvalid;
  assign fill_nx  = {1'b0, q_count} + (AW+2)'(1) - (AW+2)'(pop);
  assign room     = fill_nx < (AW+2)'(DEPTH);
  assign pop      = id_valid & id_ready;
  assign push     = recover ? rec_push : (fresh & ~redirect);
  assign push_data = recover ? rec_data : {req_tag, imem_rdata};

  always_comb begin
    case (pc_src)
      PCSRC_B:  tgt_pc = branch_address;
      PCSRC_J:  tgt_pc = jump_address;
      PCSRC_JR: tgt_pc = jr_address;
      default:  tgt_pc = '1;
    endcase
  end

  always_comb begin
    pc_nx = pc;
    if (recover)
      pc_nx = rec_pc;
    else if (trap)
      pc_nx = exception ? EXC_VEC : IRQ_VEC;
    else if (pc_src != PCSRC_SEQ)
      pc_nx = tgt_pc;
    else if (grant & ~if_flush)
      pc_nx = seq_pc;
  end

  // WAIT may reissue in the response cycle for back-to-back fetch
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    case (state)
      IDLE:
        if (redirect | ~q_full)
          state_nx = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt)
          state_nx = redirect ? DRAIN : WAIT;
      end
      WAIT:
        if (imem_rvalid) begin
          if (redirect)
            state_nx = REQ;
          else if (room) begin
            imem_req = 1'b1;
            state_nx = imem_gnt ? WAIT : REQ;
          end else
            state_nx = IDLE;
        end else if (redirect)
          state_nx = DRAIN;
      DRAIN:
        if (imem_rvalid)
          state_nx = REQ;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (!reset_b) begin
      state   <= IDLE;
      pc      <= RESET_VEC;
      req_tag <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      if (grant)
        req_tag <= {pc[XLEN-1] | intruption | exception,
                    seq_pc[XLEN-2:0]};
    end

  fetch_queue #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_b (reset_b),
    .push    (push),
    .din     (push_data),
    .pop     (pop),
    .flush   (redirect),
    .dout    (head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign imem_addr   = pc;
  assign id_valid    = ~q_empty;
  assign id_pc_plus4 = id_valid ? head[EW-1:XLEN] : '0;
  assign id_instr    = id_valid ? head[XLEN-1:0] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a transaction-level model.
// Recovery scenario included when FETCH_IRQ_CONTEXT_EN is defined.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_b;
  logic [2:0]  pc_src;
  logic [31:0] branch_address, jump_address, jr_address;
  logic        intruption, exception, if_flush;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_pc_plus4, id_instr;
  logic        irq_backup, irq_recovery;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .reset_b(reset_b), .pc_src(pc_src),
    .branch_address(branch_address), .jump_address(jump_address),
    .jr_address(jr_address), .intruption(intruption),
    .exception(exception), .if_flush(if_flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc_plus4(id_pc_plus4), .id_instr(id_instr),
    .irq_backup(irq_backup), .irq_recovery(irq_recovery)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // reference model: pc register, expected queue, one in-flight fetch
  fetch_entry_t mq[$];
  fetch_entry_t popped[$];
  logic [31:0]  m_pc, m_addr, m_tag;
  logic         m_out, m_stale;
  logic [31:0]  b_pc;
  logic         b_valid;
  fetch_entry_t b_ent;
  // memory stub
  logic         rsp_pend, spur;
  int           rsp_lat, lat_min, lat_max;
  logic [31:0]  rsp_addr;
  // grant log
  logic         got_grant;
  logic [31:0]  g_addr;
  int           g_cyc, cyc, n_pop;

  task automatic idle_in();
    pc_src = 3'b000;
    intruption = 1'b0;
    exception = 1'b0;
    if_flush = 1'b0;
    irq_backup = 1'b0;
    irq_recovery = 1'b0;
  endtask

  task automatic step();
    logic trap, redir, grant, recov, fire;
    fire = rsp_pend && rsp_lat == 0;
    imem_rvalid = fire || spur;
    imem_rdata = fire ? mem_word(rsp_addr) : $urandom;
    #1;
    got_grant = 1'b0;
    recov = 1'b0;
`ifdef FETCH_IRQ_CONTEXT_EN
    recov = irq_recovery;
`endif
    if (!reset_b) begin
      m_pc = 32'h8000_0000;
      mq.delete();
      m_out = 1'b0;
      m_stale = 1'b0;
      b_pc = 32'h8000_0000;
      b_valid = 1'b0;
    end else begin
      chk("id_valid", id_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("id_pc_plus4", id_pc_plus4, mq[0].pc_plus4);
        chk("id_instr", id_instr, mq[0].instr);
      end else
        chk("idle_payload", id_pc_plus4 | id_instr, 32'h0);
      chk("req_while_busy", imem_req & m_out & ~imem_rvalid, 0);
      if (imem_req)
        chk("imem_addr", imem_addr, m_pc);
      trap = !m_pc[31] && (intruption || exception);
      redir = recov || trap || pc_src != 3'b000 || if_flush;
      grant = imem_req && imem_gnt;
`ifdef FETCH_IRQ_CONTEXT_EN
      if (irq_backup && !recov) begin
        b_pc = m_pc;
        b_valid = mq.size() != 0;
        b_ent = b_valid ? mq[0] : '0;
      end
`endif
      if (id_valid && id_ready && !redir) begin
        popped.push_back('{pc_plus4: id_pc_plus4, instr: id_instr});
        n_pop++;
      end
      if (redir)
        mq.delete();
      else if (id_ready && mq.size() != 0)
        void'(mq.pop_front());
      if (recov && b_valid)
        mq.push_back(b_ent);
      if (imem_rvalid && m_out) begin
        if (!m_stale && !redir)
          mq.push_back('{pc_plus4: m_tag, instr: mem_word(m_addr)});
        m_out = 1'b0;
      end else if (m_out && redir)
        m_stale = 1'b1;
      if (grant) begin
        m_out = 1'b1;
        m_stale = redir;
        m_addr = m_pc;
        m_tag = {m_pc[31], m_pc[30:0] + 31'd4};
        got_grant = 1'b1;
        g_addr = imem_addr;
        g_cyc = cyc;
      end
      if (recov)
        m_pc = b_pc;
      else if (trap)
        m_pc = exception ? 32'h8000_0008 : 32'h8000_0004;
      else if (pc_src != 3'b000)
        case (pc_src)
          3'b001:  m_pc = branch_address;
          3'b010:  m_pc = jump_address;
          3'b100:  m_pc = jr_address;
          default: m_pc = 32'hFFFF_FFFF;
        endcase
      else if (grant && !if_flush)
        m_pc = {m_pc[31], m_pc[30:0] + 31'd4};
    end
    if (fire)
      rsp_pend = 1'b0;
    else if (rsp_pend)
      rsp_lat--;
    if (reset_b && imem_req && imem_gnt) begin
      rsp_pend = 1'b1;
      rsp_lat = $urandom_range(lat_min, lat_max);
      rsp_addr = imem_addr;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_grant(input int bound, output logic [31:0] a);
    a = 'x;
    for (int n = 0; n < bound; n++) begin
      step();
      if (got_grant) begin
        a = g_addr;
        break;
      end
    end
    chk("grant_timeout", got_grant, 1);
  endtask

  function automatic logic [31:0] pop_pc4(input int i);
    return (popped.size() > i) ? popped[i].pc_plus4 : 32'hxxxx_xxxx;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] ga[$];
    int gc[$];
    int rel, r;
    idle_in();
    reset_b = 1'b0;
    branch_address = '0;
    jump_address = '0;
    jr_address = '0;
    id_ready = 1'b1;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    rsp_pend = 1'b0;
    rsp_lat = 0;
    rsp_addr = '0;
    spur = 1'b0;
    lat_min = 0;
    lat_max = 0;
    cyc = 0;
    n_pop = 0;
    @(negedge clk);
    repeat (3) step();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_pc4", id_pc_plus4, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_addr", imem_addr, 32'h8000_0000);

    // release with a stray rvalid; then 1-cycle memory
    reset_b = 1'b1;
    spur = 1'b1;
    rel = cyc;
    step();
    spur = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (got_grant) begin
        ga.push_back(g_addr);
        gc.push_back(g_cyc);
      end
    end
    chk("first_req_cycle", gc.size() > 0 ? gc[0] - rel : -1, 1);
    chk("seq_addr0", ga.size() > 0 ? ga[0] : 'x, 32'h8000_0000);
    chk("seq_addr1", ga.size() > 1 ? ga[1] : 'x, 32'h8000_0004);
    chk("seq_addr2", ga.size() > 2 ? ga[2] : 'x, 32'h8000_0008);
    chk("back_to_back", gc.size() > 2 ? gc[2] - gc[0] : -1, 2);
    chk("seq_pc4_0", pop_pc4(0), 32'h8000_0004);
    chk("seq_pc4_1", pop_pc4(1), 32'h8000_0008);
    chk("seq_pc4_2", pop_pc4(2), 32'h8000_000C);

    // branch while a response is in flight
    lat_min = 2;
    lat_max = 2;
    pc_src = 3'b010;
    jump_address = 32'h0000_0100;
    step();
    idle_in();
    run_until_grant(20, a);
    chk("jump_addr", a, 32'h0000_0100);
    popped.delete();
    pc_src = 3'b001;
    branch_address = 32'h0000_0200;
    step();
    idle_in();
    run_until_grant(20, a);
    chk("branch_addr", a, 32'h0000_0200);
    chk("stale_dropped", popped.size(), 0);
    for (int n = 0; n < 10 && !id_valid; n++)
      step();
    chk("branch_head", id_pc_plus4, 32'h0000_0204);
    lat_min = 0;
    lat_max = 0;

    // user-mode trap, then fill the queue with ID stalled
    id_ready = 1'b0;
    pc_src = 3'b010;
    jump_address = 32'h0000_0040;
    step();
    idle_in();
    intruption = 1'b1;
    exception = 1'b1;
    step();
    idle_in();
    repeat (12) step();
    chk("trap_valid", id_valid, 1);
    chk("trap_head", id_pc_plus4, 32'h8000_000C);
    chk("trap_instr", id_instr, mem_word(32'h8000_0008));
    chk("full_req_low", imem_req, 0);
    intruption = 1'b1;
    exception = 1'b1;
    step();
    idle_in();
    step();
    chk("kernel_no_trap", id_pc_plus4, 32'h8000_000C);
    chk("kernel_pc", imem_addr, 32'h8000_0010);
    popped.delete();
    id_ready = 1'b1;
    repeat (8) step();
    chk("drain_pc4_0", pop_pc4(0), 32'h8000_000C);
    chk("drain_pc4_1", pop_pc4(1), 32'h8000_0010);
    chk("drain_pc4_2", pop_pc4(2), 32'h8000_0014);
    chk("drain_instr_1", popped.size() > 1 ? popped[1].instr : 'x,
        mem_word(32'h8000_000C));

    // illegal pc_src
    pc_src = 3'b011;
    step();
    idle_in();
    run_until_grant(20, a);
    chk("bad_pcsrc", a, 32'hFFFF_FFFF);

`ifdef FETCH_IRQ_CONTEXT_EN
    id_ready = 1'b0;
    pc_src = 3'b010;
    jump_address = 32'h0000_007C;
    step();
    idle_in();
    run_until_grant(20, a);
    imem_gnt = 1'b0;
    repeat (3) step();
    chk("bk_head", id_pc_plus4, 32'h0000_0080);
    irq_backup = 1'b1;
    step();
    idle_in();
    intruption = 1'b1;
    step();
    idle_in();
    imem_gnt = 1'b1;
    repeat (4) step();
    imem_gnt = 1'b0;
    irq_recovery = 1'b1;
    step();
    idle_in();
    chk("rec_addr", imem_addr, 32'h0000_0080);
    chk("rec_valid", id_valid, 1);
    chk("rec_pc4", id_pc_plus4, 32'h0000_0080);
    chk("rec_instr", id_instr, mem_word(32'h0000_007C));
    id_ready = 1'b1;
    imem_gnt = 1'b1;
`endif

    // randomised traffic against the model
    n_pop = 0;
    for (int i = 0; i < 3000; i++) begin
      id_ready = ($urandom % 4) != 0;
      imem_gnt = ($urandom % 3) != 0;
      lat_max = $urandom % 3;
      branch_address = {$urandom} & 32'hFFFF_FFFC;
      jump_address = {$urandom} & 32'hFFFF_FFFC;
      jr_address = {$urandom} & 32'hFFFF_FFFC;
      r = $urandom % 40;
      case (r)
        0: pc_src = 3'b001;
        1: pc_src = 3'b010;
        2: pc_src = 3'b100;
        3: pc_src = 3'b011 << ($urandom % 2);
        4: begin
          intruption = $urandom % 2;
          exception = ~intruption | ($urandom % 2);
        end
        5: if_flush = 1'b1;
`ifdef FETCH_IRQ_CONTEXT_EN
        6: irq_backup = 1'b1;
        7: irq_recovery = 1'b1;
`endif
        default: ;
      endcase
      step();
      idle_in();
    end
    chk("progress", n_pop > 200, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
